// File: rtl/sd_cmd_phys.sv
// SD host command-line PHY: serializes the 48-bit command frame onto the CMD pad,
// then turns the pad around and deserializes/CRC-checks the card response.
module sd_cmd_phys #(
    parameter int unsigned TIMEOUT         = 64,
    parameter int unsigned CMD_BITS        = 48,
    parameter int unsigned LONG_RESP_BITS  = 136,
    parameter int unsigned SHORT_RESP_BITS = 48
) (
    input  logic         sd_clock,
    input  logic         reset,
    input  logic         strobe_in,
    input  logic         ack_in,
    input  logic [5:0]   cmd_index,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    output logic         pad_output_input,
    output logic         pad_enable,
    output logic         pad_data_in,
    input  logic         pad_data_out,
    output logic [135:0] response,
    output logic         ack_out,
    output logic         idle_out,
    output logic         timeout_error,
    output logic         crc_error
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND      = 3'd1;
    localparam logic [2:0] WAIT_RESP = 3'd2;
    localparam logic [2:0] RECEIVE   = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    localparam logic [7:0]  SEND_LAST  = 8'(CMD_BITS - 1);
    localparam logic [7:0]  SHORT_LAST = 8'(SHORT_RESP_BITS - 1);
    localparam logic [7:0]  LONG_LAST  = 8'(LONG_RESP_BITS - 1);
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

    // Serial CRC7 (x^7 + x^3 + 1, init 0) over 40 bits, MSB first.
    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    logic [2:0]   state_q, state_d;
    logic [47:0]  frame_q, frame_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   rx_cnt_q, rx_cnt_d;
    logic [15:0]  tmo_cnt_q, tmo_cnt_d;
    logic [1:0]   resp_type_q, resp_type_d;
    logic [135:0] response_q, response_d;
    logic         timeout_q, timeout_d;
    logic         crc_err_q, crc_err_d;

    logic [39:0]  tx_body;
    logic [135:0] rx_shift;
    logic         resp_long;

    assign tx_body   = {2'b01, cmd_index, cmd_arg};
    assign rx_shift  = {response_q[134:0], pad_data_out};
    assign resp_long = (resp_type_q == 2'd2);

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        bit_cnt_d   = bit_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        resp_type_d = resp_type_q;
        response_d  = response_q;
        timeout_d   = timeout_q;
        crc_err_d   = crc_err_q;

        case (state_q)
            IDLE: begin
                if (strobe_in) begin
                    frame_d     = {tx_body, crc7_40(tx_body), 1'b1};
                    bit_cnt_d   = 8'd0;
                    resp_type_d = resp_type;
                    response_d  = '0;
                    timeout_d   = 1'b0;
                    crc_err_d   = 1'b0;
                    state_d     = SEND;
                end
            end
            SEND: begin
                frame_d = {frame_q[46:0], 1'b1};
                if (bit_cnt_q == SEND_LAST) begin
                    tmo_cnt_d = 16'd0;
                    state_d   = (resp_type_q == 2'd0) ? DONE : WAIT_RESP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                end
            end
            WAIT_RESP: begin
                // A start bit on the final count still wins over the timeout.
                if (!pad_data_out) begin
                    response_d = rx_shift;
                    rx_cnt_d   = 8'd1;
                    state_d    = RECEIVE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            RECEIVE: begin
                response_d = rx_shift;
                if (rx_cnt_q == (resp_long ? LONG_LAST : SHORT_LAST)) begin
                    if (!resp_long) begin
                        crc_err_d = (crc7_40(rx_shift[47:8]) != rx_shift[7:1]);
                    end
                    state_d = DONE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 8'd1;
                end
            end
            DONE: begin
                if (ack_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sd_clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            frame_q     <= '1;
            bit_cnt_q   <= 8'd0;
            rx_cnt_q    <= 8'd0;
            tmo_cnt_q   <= 16'd0;
            resp_type_q <= 2'd0;
            response_q  <= '0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            resp_type_q <= resp_type_d;
            response_q  <= response_d;
            timeout_q   <= timeout_d;
            crc_err_q   <= crc_err_d;
        end
    end

    always_comb begin
        pad_output_input = (state_q == SEND);
        pad_enable       = (state_q == SEND) || (state_q == WAIT_RESP) || (state_q == RECEIVE);
        pad_data_in      = (state_q == SEND) ? frame_q[47] : 1'b1;
        idle_out         = (state_q == IDLE);
        ack_out          = (state_q == DONE);
    end

    assign response      = response_q;
    assign timeout_error = timeout_q;
    assign crc_error     = crc_err_q;

endmodule

// File: tb/tb_sd_cmd_phys.sv
// Directed self-checking bench for sd_cmd_phys: frame serialization, response
// capture, CRC and timeout flags, handshake and asynchronous reset.
module tb_sd_cmd_phys;

    logic         clk = 1'b0;
    logic         reset;
    logic         strobe_in;
    logic         ack_in;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   resp_type;
    logic         pad_output_input;
    logic         pad_enable;
    logic         pad_data_in;
    logic         pad_data_out;
    logic [135:0] response;
    logic         ack_out;
    logic         idle_out;
    logic         timeout_error;
    logic         crc_error;

    int n_checks = 0;
    int n_pass   = 0;

    logic [135:0] long_pat;

    sd_cmd_phys dut (
        .sd_clock         (clk),
        .reset            (reset),
        .strobe_in        (strobe_in),
        .ack_in           (ack_in),
        .cmd_index        (cmd_index),
        .cmd_arg          (cmd_arg),
        .resp_type        (resp_type),
        .pad_output_input (pad_output_input),
        .pad_enable       (pad_enable),
        .pad_data_in      (pad_data_in),
        .pad_data_out     (pad_data_out),
        .response         (response),
        .ack_out          (ack_out),
        .idle_out         (idle_out),
        .timeout_error    (timeout_error),
        .crc_error        (crc_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe a command and capture the 48 serialized bits; optionally pulse strobe mid-frame.
    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                            input logic [47:0] exp_frame, input bit chk_frame, input bit glitch);
        logic [47:0] got;
        bit          oe_ok;
        cmd_index = idx;
        cmd_arg   = arg;
        resp_type = rt;
        strobe_in = 1'b1;
        tick();
        strobe_in = 1'b0;
        got   = '0;
        oe_ok = 1'b1;
        for (int i = 0; i < 48; i++) begin
            got   = {got[46:0], pad_data_in};
            oe_ok = oe_ok & pad_output_input & pad_enable;
            if (glitch && i == 10) begin
                strobe_in = 1'b1;
                cmd_index = 6'h3F;
                cmd_arg   = 32'hFFFF_FFFF;
            end
            if (i < 47) begin
                tick();
                strobe_in = 1'b0;
            end
        end
        if (chk_frame) check_eq("frame", got, exp_frame);
        check_eq("send_drive", oe_ok, 1);
        tick();
    endtask

    task automatic drive_resp(input logic [135:0] bits, input int n, input int gap);
        repeat (gap) tick();
        for (int i = n - 1; i >= 0; i--) begin
            if (i == 0) check_eq("rx_not_done_early", ack_out, 0);
            pad_data_out = bits[i];
            tick();
        end
        pad_data_out = 1'b1;
    endtask

    task automatic do_ack();
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check_eq("ack_clears", ack_out, 0);
        check_eq("ack_idle", idle_out, 1);
    endtask

    initial begin
        long_pat     = {8'h3F, 128'h0123456789ABCDEF_FEDCBA9876543210};
        reset        = 1'b0;
        strobe_in    = 1'b0;
        ack_in       = 1'b0;
        cmd_index    = '0;
        cmd_arg      = '0;
        resp_type    = '0;
        pad_data_out = 1'b1;

        #12;
        check_eq("rst_oe", pad_output_input, 0);
        check_eq("rst_en", pad_enable, 0);
        check_eq("rst_data", pad_data_in, 1);
        check_eq("rst_idle", idle_out, 1);
        check_eq("rst_ack", ack_out, 0);
        check_eq("rst_resp", response, 0);
        check_eq("rst_tmo", timeout_error, 0);
        check_eq("rst_crc", crc_error, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ack_in while idle does nothing
        ack_in = 1'b1;
        tick();
        ack_in = 1'b0;
        check_eq("idle_ack_ignored", idle_out, 1);
        check_eq("idle_ack_no_ack", ack_out, 0);

        // CMD0, no response; strobe pulsed mid-frame must be ignored
        send_cmd(6'd0, 32'h0, 2'd0, 48'h40_0000_0000_95, 1'b1, 1'b1);
        check_eq("cmd0_ack", ack_out, 1);
        check_eq("cmd0_tmo", timeout_error, 0);
        check_eq("cmd0_pad_off", pad_enable, 0);
        do_ack();

        // CMD8 with a good R7 response
        send_cmd(6'd8, 32'h0000_01AA, 2'd1, 48'h48_0000_01AA_87, 1'b1, 1'b0);
        check_eq("cmd8_listen_oe", pad_output_input, 0);
        check_eq("cmd8_listen_en", pad_enable, 1);
        drive_resp(136'h08_0000_01AA_13, 48, 5);
        check_eq("cmd8_ack", ack_out, 1);
        check_eq("cmd8_resp", response, 136'h08_0000_01AA_13);
        check_eq("cmd8_crc", crc_error, 0);
        check_eq("cmd8_tmo", timeout_error, 0);
        tick();
        tick();
        check_eq("cmd8_ack_held", ack_out, 1);
        do_ack();
        check_eq("cmd8_resp_hold", response, 136'h08_0000_01AA_13);

        // CMD8 with a corrupted argument bit in the response
        send_cmd(6'd8, 32'h0000_01AA, 2'd1, 48'h48_0000_01AA_87, 1'b1, 1'b0);
        drive_resp(136'h08_0000_01AB_13, 48, 5);
        check_eq("crcbad_ack", ack_out, 1);
        check_eq("crcbad_resp", response, 136'h08_0000_01AB_13);
        check_eq("crcbad_crc", crc_error, 1);
        do_ack();

        // CMD17, card silent -> timeout after 64 wait cycles
        send_cmd(6'd17, 32'h0, 2'd1, 48'h0, 1'b0, 1'b0);
        check_eq("cmd17_crc_cleared", crc_error, 0);
        repeat (63) tick();
        check_eq("cmd17_not_yet", ack_out, 0);
        tick();
        check_eq("cmd17_ack", ack_out, 1);
        check_eq("cmd17_tmo", timeout_error, 1);
        check_eq("cmd17_resp", response, 0);
        do_ack();
        check_eq("cmd17_tmo_hold", timeout_error, 1);

        // CMD2, 136-bit response
        send_cmd(6'd2, 32'h0, 2'd2, 48'h42_0000_0000_4D, 1'b1, 1'b0);
        check_eq("cmd2_tmo_cleared", timeout_error, 0);
        drive_resp(long_pat, 136, 2);
        check_eq("cmd2_ack", ack_out, 1);
        check_eq("cmd2_resp", response, long_pat);
        check_eq("cmd2_crc", crc_error, 0);

        // Reset while in DONE clears the held result asynchronously
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_done_resp", response, 0);
        check_eq("rst_done_ack", ack_out, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Reset mid-SEND at bit 20
        cmd_index = 6'd17;
        cmd_arg   = 32'h1234_5678;
        resp_type = 2'd1;
        strobe_in = 1'b1;
        tick();
        strobe_in = 1'b0;
        repeat (20) tick();
        check_eq("midsend_driving", pad_output_input, 1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("midrst_oe", pad_output_input, 0);
        check_eq("midrst_en", pad_enable, 0);
        check_eq("midrst_data", pad_data_in, 1);
        check_eq("midrst_idle", idle_out, 1);
        check_eq("midrst_ack", ack_out, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick();
        check_eq("midrst_stays_idle", idle_out, 1);
        check_eq("midrst_no_ack", ack_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sd_cmd_phys.md
Name: sd_cmd_phys

Overview:
- Command-line physical layer of the SD host. It sits directly upstream of the CMD pad.
- Builds the 48-bit command frame from index and argument, generating the start, transmission, CRC7 and end bits. Shifts the frame out MSB-first on the pad, one bit per sd_clock.
- Turns the pad around, waits for the card's response start bit, deserializes the response and checks its CRC7.
- Reports completion to the command control logic through a strobe/ack handshake.

Parameters:
- TIMEOUT, 64: maximum sd_clock cycles in WAIT_RESP without a start bit before timeout_error.
- CMD_BITS, 48: command frame length.
- LONG_RESP_BITS, 136: R2 response length.
- SHORT_RESP_BITS, 48: R1/R3/R6/R7 response length.

Ports:
- sd_clock  in  1  SD card clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- strobe_in  in  1  start request from command control; sampled only in IDLE.
- ack_in  in  1  control acknowledges result; sampled only in DONE.
- cmd_index  in  6  command index.
- cmd_arg  in  32  command argument.
- resp_type  in  2  0 = none, 1 = 48-bit, 2 = 136-bit, 3 = treated as 1.
- pad_output_input  out  1  to pad: 1 = drive CMD line, 0 = listen.
- pad_enable  out  1  to pad: pad enabled.
- pad_data_in  out  1  serial bit to the pad.
- pad_data_out  in  1  serial bit received from the pad.
- response  out  136  received response, right-aligned; unused upper bits are 0.
- ack_out  out  1  result valid, held until ack_in.
- idle_out  out  1  block in IDLE.
- timeout_error  out  1  no start bit within TIMEOUT.
- crc_error  out  1  CRC7 mismatch on a 48-bit response.

Behaviour:
- Reset (reset = 0, async, any state):
  - State goes to IDLE.
  - pad_output_input = 0, pad_enable = 0, pad_data_in = 1.
  - response = 0, ack_out = 0, timeout_error = 0, crc_error = 0, idle_out = 1.
  - Reset mid-frame aborts immediately; no partial result is reported.
- States: IDLE, SEND, WAIT_RESP, RECEIVE, DONE.
- IDLE:
  - idle_out = 1, pad_data_in = 1.
  - strobe_in = 1 at an edge: latch cmd_index, cmd_arg and resp_type; clear response and the error flags; go to SEND.
  - strobe_in is ignored in every other state.
- SEND:
  - pad_enable = 1, pad_output_input = 1.
  - Frame = {0, 1, cmd_index, cmd_arg, crc7, 1}.
  - crc7 uses polynomial x^7 + x^3 + 1, initial value 0, computed serially over frame bits 47..8.
  - Bit 47 appears on pad_data_in in the first SEND cycle; bit 0 in the 48th cycle. 48 cycles total.
  - After bit 0: resp_type = 0 goes to DONE; otherwise go to WAIT_RESP with the timeout counter cleared.
- WAIT_RESP:
  - pad_output_input = 0, pad_enable = 1, pad_data_in = 1.
  - Counter increments every cycle.
  - pad_data_out = 0 sampled: that bit is the response start bit; shift it in and go to RECEIVE.
  - Counter reaches TIMEOUT-1 with no start bit: timeout_error = 1, go to DONE.
  - If the start bit and the final count coincide, the start bit wins.
- RECEIVE:
  - Shift pad_data_out in, LSB-side, one bit per cycle, until SHORT_RESP_BITS or LONG_RESP_BITS bits (including the start bit) are held.
  - Then go to DONE.
  - 48-bit response: crc_error = 1 if the CRC7 over received bits 47..8 differs from received bits 7..1.
  - 136-bit response: crc_error stays 0.
- DONE:
  - pad_output_input = 0, pad_enable = 0.
  - ack_out = 1; response and error flags stable.
  - ack_in = 1 at an edge: ack_out = 0, go to IDLE. Outputs other than ack_out and idle_out hold until the next strobe.
- Total latency with resp_type = 0: strobe edge to ack_out = 1 is 49 edges.

Test Plan:
- CMD0, arg 0, resp_type 0 -> pad_data_in carries 0x40_0000_0000_95 MSB-first over 48 cycles with pad_output_input = 1; ack_out on the next cycle; timeout_error = 0.
- CMD8, arg 0x000001AA, resp_type 1 -> frame 0x48_0000_01AA_87. Card model drives 0x08_0000_01AA_13 after 5 idle cycles -> response[47:0] = 0x08000001AA13, crc_error = 0, ack_out = 1 until ack_in.
- Same as the CMD8 case but with one argument bit of the response flipped -> crc_error = 1, response captures the corrupted value.
- CMD17, resp_type 1, card never drives low -> timeout_error = 1 after 64 WAIT_RESP cycles, response = 0.
- CMD2, resp_type 2, 136-bit pattern with start bit 0 -> response equals the pattern; crc_error = 0; RECEIVE lasts 136 cycles.
- Reset pulled low at SEND bit 20 -> outputs return to their reset values asynchronously. strobe_in pulsed while in SEND, and ack_in pulsed in IDLE -> no effect.
